// File: rtl/lemmings_pkg.sv
// Shared width helpers and the action priority decode for the lemmings terrain model.
// The LEMMINGS_DIG_EN macro (see lemmings_terrain) controls whether digging is honoured.
package lemmings_pkg;

  function automatic int calc_xw(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  function automatic int calc_yw(input int depth);
    return (depth > 0) ? $clog2(depth + 1) : 1;
  endfunction

  function automatic int calc_dw(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_FALL,
    ACT_DIG,
    ACT_LEFT,
    ACT_RIGHT
  } action_e;

  // Highest priority first; spawn and reset are handled by the caller.
  function automatic action_e decode_action(input logic aaah, input logic dig,
                                            input logic wl, input logic wr,
                                            input logic bl, input logic br);
    if (aaah)                  return ACT_FALL;
    else if (dig)              return ACT_DIG;
    else if (wl && !wr && !bl) return ACT_LEFT;
    else if (wr && !wl && !br) return ACT_RIGHT;
    else                       return ACT_HOLD;
  endfunction

endpackage

// File: rtl/lemmings_neighbor_decode.sv
// Turns the lemming position and the three surrounding floor heights into
// the bump_left / bump_right / ground feedback seen by the walker FSM.
module lemmings_neighbor_decode
  import lemmings_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int XW    = 4,
  parameter int YW    = 4
) (
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  logic [YW-1:0] h_left,
  input  logic [YW-1:0] h_here,
  input  logic [YW-1:0] h_right,
  output logic          bump_left,
  output logic          bump_right,
  output logic          ground
);

  // Same rule on both sides: world edge, or a neighbour taller than the lemming.
  function automatic logic side_bump(input logic at_edge, input logic [YW-1:0] h_nb,
                                     input logic [YW-1:0] y_cur);
    return at_edge || (h_nb > y_cur);
  endfunction

  assign bump_left  = side_bump(x == '0, h_left, y);
  assign bump_right = side_bump(x == XW'(WIDTH - 1), h_right, y);
  assign ground     = (y == h_here);

endmodule

// File: rtl/lemmings_terrain.sv
// World model closing the loop around the Lemmings4 walker FSM: height map, lemming
// position and bump/ground feedback. Define LEMMINGS_DIG_EN to let digging erode the map.
module lemmings_terrain
  import lemmings_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int DEPTH       = 8,
  parameter int INIT_HEIGHT = 4,
  parameter int SPAWN_X     = 0,
  parameter int DIG_CYCLES  = 3
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst,
  input  logic                         walk_left,
  input  logic                         walk_right,
  input  logic                         aaah,
  input  logic                         digging,
  input  logic                         spawn,
  input  logic                         load_en,
  input  logic [calc_xw(WIDTH)-1:0]    load_col,
  input  logic [calc_yw(DEPTH)-1:0]    load_height,
  output logic                         bump_left,
  output logic                         bump_right,
  output logic                         ground,
  output logic [calc_xw(WIDTH)-1:0]    lem_x,
  output logic [calc_yw(DEPTH)-1:0]    lem_y
);

  localparam int XW = calc_xw(WIDTH);
  localparam int YW = calc_yw(DEPTH);

  logic [YW-1:0] floor_h_q [WIDTH];
  logic [YW-1:0] floor_h_d [WIDTH];
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  logic [YW-1:0] h_left, h_here, h_right;
  logic [YW-1:0] load_clamped;
  logic          bump_l, bump_r, on_ground;
  logic          dig_req;
  action_e       act;

`ifdef LEMMINGS_DIG_EN
  localparam int DW = calc_dw(DIG_CYCLES);
  logic [DW-1:0] dcnt_q, dcnt_d;
  assign dig_req = digging;
`else
  logic unused_digging;
  assign unused_digging = digging;
  assign dig_req        = 1'b0;
`endif

  assign h_here  = floor_h_q[x_q];
  assign h_left  = (x_q != '0) ? floor_h_q[x_q - 1'b1] : '0;
  assign h_right = (x_q != XW'(WIDTH - 1)) ? floor_h_q[x_q + 1'b1] : '0;

  assign load_clamped = (load_height > YW'(DEPTH)) ? YW'(DEPTH) : load_height;

  lemmings_neighbor_decode #(
    .WIDTH (WIDTH),
    .XW    (XW),
    .YW    (YW)
  ) u_decode (
    .x          (x_q),
    .y          (y_q),
    .h_left     (h_left),
    .h_here     (h_here),
    .h_right    (h_right),
    .bump_left  (bump_l),
    .bump_right (bump_r),
    .ground     (on_ground)
  );

  assign bump_left  = bump_l;
  assign bump_right = bump_r;
  assign ground     = on_ground;
  assign lem_x      = x_q;
  assign lem_y      = y_q;

  always_comb begin
    // NOTE: every _d signal gets a default first so no path leaves it unassigned (no latches).
    floor_h_d = floor_h_q;
    x_d       = x_q;
    y_d       = y_q;
`ifdef LEMMINGS_DIG_EN
    dcnt_d    = '0;
`endif
    act = decode_action(aaah, dig_req, walk_left, walk_right, bump_l, bump_r);

    if (spawn) begin
      x_d = XW'(SPAWN_X);
      y_d = YW'(DEPTH);
    end else begin
      case (act)
        ACT_FALL:  if (y_q > h_here) y_d = y_q - 1'b1;
`ifdef LEMMINGS_DIG_EN
        ACT_DIG: begin
          if (dcnt_q != DW'(DIG_CYCLES - 1)) dcnt_d = dcnt_q + 1'b1;
          else if (h_here != '0)             floor_h_d[x_q] = h_here - 1'b1;
          else                               dcnt_d = dcnt_q;
        end
`endif
        ACT_LEFT:  x_d = x_q - 1'b1;
        ACT_RIGHT: x_d = x_q + 1'b1;
        default:   ;
      endcase
    end

    // A load overrides a same-column dig; the lemming is never left buried.
    if (load_en && (32'(load_col) < WIDTH)) floor_h_d[load_col] = load_clamped;
    if (floor_h_d[x_d] > y_d) y_d = floor_h_d[x_d];
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      // NOTE: the height map is flop-based and reset, because reset defines the terrain.
      floor_h_q <= '{default: YW'(INIT_HEIGHT)};
      x_q       <= XW'(SPAWN_X);
      y_q       <= YW'(INIT_HEIGHT);
`ifdef LEMMINGS_DIG_EN
      dcnt_q    <= '0;
`endif
    end else begin
      floor_h_q <= floor_h_d;
      x_q       <= x_d;
      y_q       <= y_d;
`ifdef LEMMINGS_DIG_EN
      dcnt_q    <= dcnt_d;
`endif
    end
  end

endmodule
